// File: rtl/encaps_ctrl.sv
// Sequencer for the encapsulate core: LFSR reset/warm-up, key-load gating,
// fixed-latency run timing and a valid/ready request/response handshake.
module encaps_ctrl #(
  parameter int unsigned LFSR_RST_CYC = 2,
  parameter int unsigned LFSR_WARMUP  = 18,
  parameter int unsigned ENC_LATENCY  = 2000,
  parameter int unsigned CNT_W        = 11
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pk_wr,
  input  logic req_valid,
  output logic req_ready,
  input  logic abort,
  output logic out_valid,
  input  logic out_ready,
  output logic lfsr_rst,
  output logic ovr_rst1,
  output logic pk_load_en,
  output logic capture_en,
  output logic pk_loaded,
  output logic pk_err
);

  typedef enum logic [2:0] {
    S_LFSR_RST = 3'd0,
    S_WARMUP   = 3'd1,
    S_IDLE     = 3'd2,
    S_KICK     = 3'd3,
    S_BUSY     = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(LFSR_RST_CYC - 1);
  localparam logic [CNT_W-1:0] WARM_LAST = CNT_W'(LFSR_WARMUP - 1);
  localparam logic [CNT_W-1:0] LAT_LAST  = CNT_W'(ENC_LATENCY - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pk_loaded_q, pk_loaded_d;
  logic             pk_err_q, pk_err_d;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of its peers; blocking here would create order races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_LFSR_RST;
      cnt_q       <= '0;
      pk_loaded_q <= 1'b0;
      pk_err_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pk_loaded_q <= pk_loaded_d;
      pk_err_q    <= pk_err_d;
    end
  end

  // NOTE: every signal driven below gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lfsr_rst   = 1'b0;
    req_ready  = 1'b0;
    ovr_rst1   = 1'b0;
    pk_load_en = 1'b0;
    capture_en = 1'b0;
    out_valid  = 1'b0;

    unique case (state_q)
      S_LFSR_RST: begin
        lfsr_rst = 1'b1;
        if (cnt_q == RST_LAST) begin
          state_d = S_WARMUP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_WARMUP: begin
        if (cnt_q == WARM_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        // A key write in the same cycle holds off the request.
        pk_load_en = pk_wr;
        req_ready  = pk_loaded_q & ~pk_wr;
        cnt_d      = '0;
        if (req_valid && pk_loaded_q && !pk_wr) state_d = S_KICK;
      end
      S_KICK: begin
        ovr_rst1 = 1'b1;
        cnt_d    = '0;
        state_d  = abort ? S_IDLE : S_BUSY;
      end
      S_BUSY: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAT_LAST) begin
          capture_en = 1'b1;
          state_d    = S_DONE;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_DONE: begin
        out_valid = 1'b1;
        cnt_d     = '0;
        if (out_ready) state_d = S_IDLE;
      end
      default: begin
        state_d = S_LFSR_RST;
        cnt_d   = '0;
      end
    endcase
  end

  // Key writes outside IDLE are dropped and flagged one cycle later.
  assign pk_loaded_d = pk_loaded_q | (pk_wr & (state_q == S_IDLE));
  assign pk_err_d    = pk_wr & (state_q != S_IDLE);

  assign pk_loaded = pk_loaded_q;
  assign pk_err    = pk_err_q;

endmodule

// File: tb/tb_encaps_ctrl.sv
// Bench for encaps_ctrl: directed scenarios plus a randomized run scored
// against a cycle-time model of the sequencing rules.
module tb_encaps_ctrl;
  localparam int L  = 8;
  localparam int RC = 2;
  localparam int WU = 18;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pk_wr = 1'b0, req_valid = 1'b0, abort = 1'b0, out_ready = 1'b0;
  logic req_ready, out_valid, lfsr_rst, ovr_rst1, pk_load_en, capture_en;
  logic pk_loaded, pk_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  encaps_ctrl #(
    .LFSR_RST_CYC(RC), .LFSR_WARMUP(WU), .ENC_LATENCY(L), .CNT_W(11)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pk_wr(pk_wr), .req_valid(req_valid),
    .req_ready(req_ready), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .lfsr_rst(lfsr_rst), .ovr_rst1(ovr_rst1),
    .pk_load_en(pk_load_en), .capture_en(capture_en),
    .pk_loaded(pk_loaded), .pk_err(pk_err)
  );

  function automatic logic [7:0] outs();
    return {lfsr_rst, req_ready, ovr_rst1, pk_load_en,
            capture_en, out_valid, pk_loaded, pk_err};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    pk_wr = 1'b0; req_valid = 1'b0; abort = 1'b0; out_ready = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    #3;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic handshake();
    req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] exp;
    clear_inputs();
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'b1000_0000) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", outs(), 8'b1000_0000);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    pk_wr = 1'b1;
    for (int t = 0; t <= RC + WU; t++) begin
      #1;
      exp = {t < RC, 1'b0, 1'b0, t == RC + WU, 1'b0, 1'b0, 1'b0, t >= 1};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL reset_seq t=%0d got %b exp %b", t, outs(), exp);
      end
      tick();
    end
    pk_wr = 1'b0;
    #1;
    checks++;
    if (outs() !== 8'b0100_0010) begin
      errors++;
      $display("FAIL reset_key_ready got %b exp %b", outs(), 8'b0100_0010);
    end
  endtask

  task automatic test_basic();
    logic [3:0] got, exp;
    req_valid = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL basic_accept got %b exp 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      out_ready = (k == 12);
      #1;
      got = {ovr_rst1, capture_en, out_valid, req_ready};
      exp = {k == 1, k == L + 1, k >= L + 2 && k <= 12, k == 13};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL basic_run k=%0d got %b exp %b", k, got, exp);
      end
      tick();
    end
    out_ready = 1'b0;
  endtask

  task automatic test_no_key();
    do_reset();
    repeat (RC + WU) tick();
    req_valid = 1'b1;
    for (int i = 0; i < 30; i++) begin
      #1;
      checks++;
      if ({req_ready, ovr_rst1} !== 2'b00) begin
        errors++;
        $display("FAIL nokey_held i=%0d got %b exp 00", i, {req_ready, ovr_rst1});
      end
      tick();
    end
    pk_wr = 1'b1;
    #1;
    checks++;
    if ({req_ready, pk_load_en} !== 2'b01) begin
      errors++;
      $display("FAIL nokey_load_wins got %b exp 01", {req_ready, pk_load_en});
    end
    tick();
    pk_wr = 1'b0;
    #1;
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL nokey_ready_after_load got %b exp 1", req_ready);
    end
    tick();
    req_valid = 1'b0;
    #1;
    checks++;
    if (ovr_rst1 !== 1'b1) begin
      errors++;
      $display("FAIL nokey_kick got %b exp 1", ovr_rst1);
    end
    repeat (L + 1) tick();
    #1;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL nokey_done got %b exp 1", out_valid);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_pk_wr_busy();
    logic [4:0] got, exp;
    handshake();
    for (int k = 1; k <= 11; k++) begin
      pk_wr     = (k == 4);
      out_ready = (k == 11);
      #1;
      got = {pk_load_en, pk_err, capture_en, out_valid, pk_loaded};
      exp = {1'b0, k == 5, k == L + 1, k >= L + 2, 1'b1};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL pkwr_busy k=%0d got %b exp %b", k, got, exp);
      end
      tick();
    end
    pk_wr = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_abort(input int ak);
    logic [3:0] got, exp;
    handshake();
    for (int k = 1; k <= 14; k++) begin
      abort = (k == ak);
      #1;
      got = {ovr_rst1, capture_en, out_valid, req_ready};
      exp = {k == 1, 1'b0, 1'b0, k > ak};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL abort_at%0d k=%0d got %b exp %b", ak, k, got, exp);
      end
      tick();
    end
    abort = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [2:0] exp;
    for (int rep = 0; rep < 2; rep++) begin
      handshake();
      if (rep == 0) repeat (4) tick();
      else repeat (L + 1) tick();
      if (rep == 1) begin
        #1;
        checks++;
        if (out_valid !== 1'b1) begin
          errors++;
          $display("FAIL done_before_reset got %b exp 1", out_valid);
        end
      end
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (outs() !== 8'b1000_0000) begin
        errors++;
        $display("FAIL mid_reset rep=%0d got %b exp %b", rep, outs(), 8'b1000_0000);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int t = 0; t <= RC + WU; t++) begin
        pk_wr = (t == RC + WU);
        #1;
        exp = {t < RC, 1'b0, 1'b0};
        checks++;
        if ({lfsr_rst, req_ready, pk_loaded} !== exp) begin
          errors++;
          $display("FAIL mid_reset_seq rep=%0d t=%0d got %b exp %b",
                   rep, t, {lfsr_rst, req_ready, pk_loaded}, exp);
        end
        tick();
      end
      pk_wr = 1'b0;
      #1;
      checks++;
      if ({req_ready, pk_loaded} !== 2'b11) begin
        errors++;
        $display("FAIL mid_reset_reload rep=%0d got %b exp 11", rep, {req_ready, pk_loaded});
      end
    end
  endtask

  // Model in terms of elapsed cycles: t counts edges since reset release,
  // acc is the cycle of the accepted request (-1 when nothing in flight).
  task automatic test_random();
    int t = 0, acc = -1;
    bit loaded = 0, have = 0, err_q = 0, err_n, idle_now;
    logic [7:0] exp;
    do_reset();
    for (int cyc = 0; cyc < 1500; cyc++) begin
      pk_wr     = ($urandom % 16) == 0;
      req_valid = ($urandom % 4) != 0;
      abort     = ($urandom % 32) == 0;
      out_ready = ($urandom % 2) == 0;
      #1;
      idle_now = (t >= RC + WU) && (acc < 0) && !have;
      exp = {t < RC, idle_now && loaded && !pk_wr, acc >= 0 && t == acc + 1,
             idle_now && pk_wr, acc >= 0 && t == acc + 1 + L && !abort,
             have, loaded, err_q};
      checks++;
      if (outs() !== exp) begin
        errors++;
        $display("FAIL random cyc=%0d got %b exp %b", cyc, outs(), exp);
      end
      err_n = pk_wr && !idle_now;
      if (idle_now && pk_wr) loaded = 1;
      else if (idle_now && req_valid && loaded) acc = t;
      else if (acc >= 0 && abort) acc = -1;
      else if (acc >= 0 && t == acc + 1 + L) begin
        acc  = -1;
        have = 1;
      end else if (have && out_ready) have = 0;
      err_q = err_n;
      t++;
      tick();
    end
    clear_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_no_key();
    test_pk_wr_busy();
    test_abort(1);
    test_abort(5);
    test_abort(L + 1);
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
